demux_req_scheduler: RTL and testbench
======================================

// Module: demux_req_scheduler
// PURPOSE
//  Shares one registered 1-to-2**SEL_W demux tree (in/sel/clk interface, registered leaf stage) among
//  NUM_REQ requesters. Per-cycle round-robin arbitration; one (sel,data) pair drives the tree per cycle.
//  Also provides a SCAN mode that walks sel over an address range, pulsing in=1 on each address.
//  Reports completion once the demux's registered outputs show the write.
// PARAMETERS
//  NUM_REQ    4   number of requesters (>=2)
//  SEL_W      10  demux select width; tree has 2**SEL_W outputs
//  DEMUX_LAT  1   register stages between dmx_in/dmx_sel and the demux outputs
// PORTS
//  clk         in   1               rising-edge clock
//  rst         in   1               synchronous, active-high reset
//  req_valid   in   NUM_REQ         request present, one bit per requester
//  req_ready   out  NUM_REQ         one-hot grant; transfer when valid&ready
//  req_sel     in   NUM_REQ*SEL_W   target address; requester i in [i*SEL_W +: SEL_W]
//  req_data    in   NUM_REQ         bit to drive on the demux input
//  scan_start  in   1               1-cycle pulse: begin scan, sampled only in IDLE/ARB
//  scan_lo     in   SEL_W           first scan address, sampled with scan_start
//  scan_hi     in   SEL_W           last scan address (inclusive), sampled with scan_start
//  dmx_in      out  1               to demux in (registered)
//  dmx_sel     out  SEL_W           to demux sel (registered)
//  done_valid  out  1               write visible at demux outputs this cycle
//  done_id     out  $clog2(NUM_REQ) requester of completed write; NUM_REQ-1... n/a for scan (0)
//  done_scan   out  1               completed write came from SCAN
//  busy        out  1               scan active or any write in flight
// BEHAVIOUR
//  Reset: req_ready=0, dmx_in=0, dmx_sel=0, done_*=0, busy=0, RR pointer=0, state=ARB, pipe cleared.
//  States: ARB (serve requests), SCAN (walk range). No other states.
//  ARB: req_ready combinational = one-hot round-robin pick among req_valid, searching from pointer.
//   - Grant to i at edge t: dmx_in<=req_data[i], dmx_sel<=req_sel[i] visible from t+1; ptr<=(i+1)%NUM_REQ.
//   - No valid requester: dmx_in<=0, dmx_sel holds last value, pointer unchanged.
//   - scan_start in ARB: no grant that cycle (req_ready=0); latch lo/hi, cnt<=scan_lo; go SCAN.
//  SCAN: req_ready=0. Each cycle dmx_in<=1, dmx_sel<=cnt; cnt<=cnt+1 mod 2**SEL_W.
//   - Exit after driving scan_hi; next cycle back in ARB. Length = ((hi-lo) mod 2**SEL_W)+1.
//   - hi<lo wraps through 2**SEL_W-1 -> 0. lo==hi: one address. scan_start ignored while in SCAN.
//  Completion: write issued at edge t -> done_valid=1 on cycle t+1+DEMUX_LAT with done_id/done_scan;
//   implemented as (DEMUX_LAT+1)-deep valid/id/scan shift pipe. Idle cycles produce done_valid=0.
//  busy = (state==SCAN) | any pipe stage valid.
//  Throughput: one write per cycle, back-to-back; grants never stall except the scan_start cycle.
//  Reset mid-scan or mid-pipe: all of the above reset values next cycle; no done for aborted writes.
// STRUCTURE
//  Package demux_ctrl_pkg: state enum {ARB, SCAN}; localparam ID_W=$clog2(NUM_REQ) helper.
//  Sub-module rr_arbiter (NUM_REQ): req vector + pointer -> one-hot grant + encoded index, comb.
//  Top: FSM, scan counter, output regs, completion pipe.
// TESTING
//  1 All 4 valid continuously, sel=i*10 -> grants 0,1,2,3,0.. one per cycle; dmx_sel follows 1 cycle later.
//  2 Req 2 alone, sel=0x3FF,data=1 -> dmx_sel=0x3FF,dmx_in=1 at t+1; done_valid,id=2 at t+2 (DEMUX_LAT=1).
//  3 scan_start lo=5 hi=8 with reqs valid -> req_ready=0 for 5 cycles; dmx_sel 5,6,7,8 with in=1; then ARB.
//  4 Scan lo=0x3FE hi=0x001 -> dmx_sel 0x3FE,0x3FF,0x000,0x001 then exit; 4 done_scan pulses.
//  5 rst asserted 2nd cycle of a scan -> next cycle dmx_in=0,sel=0,busy=0; no further done pulses.
//  6 No requests after burst -> dmx_in=0, dmx_sel holds last, busy falls after pipe drains.

Source files
------------

// File: rtl/demux_ctrl_pkg.sv
// Shared types for the demux request scheduler: FSM state and an id-width helper.
// No logic, so there is no latency and no backpressure.
package demux_ctrl_pkg;

  typedef enum logic [0:0] {
    ARB  = 1'b0,
    SCAN = 1'b1
  } state_t;

  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: one-hot grant plus encoded index, searching upward from ptr. Combinational.
// Zero latency; an empty req vector gives any=0 and an all-zero grant.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    idx,
  output logic               any
);

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      int j;
      j = (int'(ptr) + k) % NUM_REQ;
      if (!any && req[j]) begin
        any      = 1'b1;
        grant[j] = 1'b1;
        idx      = ID_W'(j);
      end
    end
  end

endmodule

// File: rtl/demux_req_scheduler.sv
// Arbitrates NUM_REQ requesters (or a scan walk) onto one registered demux; one write per cycle.
// dmx_* valid one cycle after grant, done DEMUX_LAT later; req_ready drops only in SCAN and on scan_start.
module demux_req_scheduler
  import demux_ctrl_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int SEL_W     = 10,
  parameter int DEMUX_LAT = 1,
  localparam int ID_W     = id_w(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*SEL_W-1:0] req_sel,
  input  logic [NUM_REQ-1:0]       req_data,
  input  logic                     scan_start,
  input  logic [SEL_W-1:0]         scan_lo,
  input  logic [SEL_W-1:0]         scan_hi,
  output logic                     dmx_in,
  output logic [SEL_W-1:0]         dmx_sel,
  output logic                     done_valid,
  output logic [ID_W-1:0]          done_id,
  output logic                     done_scan,
  output logic                     busy
);

  localparam int DEPTH = DEMUX_LAT + 1;

  state_t             state;
  logic [ID_W-1:0]    ptr;
  logic [SEL_W-1:0]   cnt;
  logic [SEL_W-1:0]   hi;
  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    gnt_idx;
  logic               gnt_any;
  logic               arb_go;
  logic               wr_vld;

  logic [DEPTH-1:0]   pipe_vld;
  logic [DEPTH-1:0]   pipe_scan;
  logic [ID_W-1:0]    pipe_id [DEPTH];

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .req   (req_valid),
    .ptr   (ptr),
    .grant (grant),
    .idx   (gnt_idx),
    .any   (gnt_any)
  );

  // scan_start steals the arbitration cycle so the scan begins cleanly next edge
  assign arb_go    = (state == ARB) && !scan_start;
  assign req_ready = arb_go ? grant : '0;
  assign wr_vld    = (state == SCAN) || (arb_go && gnt_any);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ARB;
      ptr       <= '0;
      cnt       <= '0;
      hi        <= '0;
      dmx_in    <= 1'b0;
      dmx_sel   <= '0;
      pipe_vld  <= '0;
      pipe_scan <= '0;
      for (int s = 0; s < DEPTH; s++) pipe_id[s] <= '0;
    end else begin
      case (state)
        ARB: begin
          if (scan_start) begin
            dmx_in <= 1'b0;
            cnt    <= scan_lo;
            hi     <= scan_hi;
            state  <= SCAN;
          end else if (gnt_any) begin
            dmx_in  <= req_data[gnt_idx];
            dmx_sel <= req_sel[int'(gnt_idx)*SEL_W +: SEL_W];
            ptr     <= (gnt_idx == ID_W'(NUM_REQ-1)) ? '0 : gnt_idx + 1'b1;
          end else begin
            dmx_in <= 1'b0;
          end
        end
        SCAN: begin
          dmx_in  <= 1'b1;
          dmx_sel <= cnt;
          cnt     <= cnt + 1'b1;
          if (cnt == hi) state <= ARB;
        end
        default: state <= ARB;
      endcase

      // completion pipe tracks each write until it shows at the demux leaves
      for (int s = DEPTH-1; s > 0; s--) begin
        pipe_vld[s]  <= pipe_vld[s-1];
        pipe_scan[s] <= pipe_scan[s-1];
        pipe_id[s]   <= pipe_id[s-1];
      end
      pipe_vld[0]  <= wr_vld;
      pipe_scan[0] <= wr_vld && (state == SCAN);
      pipe_id[0]   <= (wr_vld && (state == ARB)) ? gnt_idx : '0;
    end
  end

  assign done_valid = pipe_vld[DEPTH-1];
  assign done_scan  = pipe_scan[DEPTH-1];
  assign done_id    = pipe_id[DEPTH-1];
  assign busy       = (state == SCAN) || (|pipe_vld);

endmodule

// File: tb/tb_demux_req_scheduler.sv
// Cycle-level reference model plus done scoreboard for demux_req_scheduler.
module tb_demux_req_scheduler;

  localparam int N   = 4;
  localparam int SW  = 10;
  localparam int LAT = 1;
  localparam int IW  = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_ready;
  logic [N*SW-1:0] req_sel = '0;
  logic [N-1:0]    req_data = '0;
  logic            scan_start = 1'b0;
  logic [SW-1:0]   scan_lo = '0;
  logic [SW-1:0]   scan_hi = '0;
  logic            dmx_in;
  logic [SW-1:0]   dmx_sel;
  logic            done_valid;
  logic [IW-1:0]   done_id;
  logic            done_scan;
  logic            busy;

  demux_req_scheduler #(.NUM_REQ(N), .SEL_W(SW), .DEMUX_LAT(LAT)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_sel(req_sel), .req_data(req_data), .scan_start(scan_start),
    .scan_lo(scan_lo), .scan_hi(scan_hi), .dmx_in(dmx_in), .dmx_sel(dmx_sel),
    .done_valid(done_valid), .done_id(done_id), .done_scan(done_scan), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int due;
    int id;
    bit scan;
  } done_t;

  done_t sb[$];
  int total = 0;
  int bad = 0;
  int cyc = 0;

  int          m_ptr = 0;
  bit          m_scan = 1'b0;
  logic [SW-1:0] m_cnt = '0;
  logic [SW-1:0] m_hi = '0;
  logic        m_in = 1'b0;
  logic [SW-1:0] m_sel = '0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=0x%0h exp=0x%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic set_req(input int i, input bit v, input logic [SW-1:0] sel, input bit d);
    req_valid[i]          = v;
    req_sel[i*SW +: SW]   = sel;
    req_data[i]           = d;
  endtask

  // Check outputs at the negedge, then advance the model across the next rising edge.
  task automatic step();
    logic [N-1:0] exp_rdy;
    int pick;
    done_t e;
    @(negedge clk);
    exp_rdy = '0;
    pick = -1;
    if (!m_scan && !scan_start) begin
      for (int k = 0; k < N; k++) begin
        int j;
        j = (m_ptr + k) % N;
        if (pick < 0 && req_valid[j]) pick = j;
      end
      if (pick >= 0) exp_rdy[pick] = 1'b1;
    end
    check_eq("req_ready", 32'(req_ready), 32'(exp_rdy));
    check_eq("dmx_in", 32'(dmx_in), 32'(m_in));
    check_eq("dmx_sel", 32'(dmx_sel), 32'(m_sel));
    check_eq("busy", 32'(busy), 32'(m_scan || (sb.size() > 0)));
    if (sb.size() > 0 && sb[0].due == cyc) begin
      e = sb.pop_front();
      check_eq("done_valid", 32'(done_valid), 32'd1);
      check_eq("done_id", 32'(done_id), 32'(e.id));
      check_eq("done_scan", 32'(done_scan), 32'(e.scan));
    end else begin
      check_eq("done_idle", 32'(done_valid), 32'd0);
    end

    if (rst) begin
      sb.delete();
      m_ptr = 0; m_scan = 1'b0; m_in = 1'b0; m_sel = '0;
    end else if (m_scan) begin
      m_in  = 1'b1;
      m_sel = m_cnt;
      sb.push_back('{due: cyc + 1 + LAT, id: 0, scan: 1'b1});
      if (m_cnt == m_hi) m_scan = 1'b0;
      m_cnt = m_cnt + 1'b1;
    end else if (scan_start) begin
      m_scan = 1'b1;
      m_cnt  = scan_lo;
      m_hi   = scan_hi;
      m_in   = 1'b0;
    end else if (pick >= 0) begin
      m_in  = req_data[pick];
      m_sel = req_sel[pick*SW +: SW];
      sb.push_back('{due: cyc + 1 + LAT, id: pick, scan: 1'b0});
      m_ptr = (pick + 1) % N;
    end else begin
      m_in = 1'b0;
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic drain();
    int n = 0;
    req_valid  = '0;
    scan_start = 1'b0;
    while ((m_scan || sb.size() > 0) && n < 40) begin
      step();
      n++;
    end
    step();
    check_eq("drained", 32'(sb.size()), 32'd0);
  endtask

  task automatic pulse_scan(input logic [SW-1:0] lo, input logic [SW-1:0] hi);
    scan_start = 1'b1; scan_lo = lo; scan_hi = hi;
    step();
    scan_start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc);
    $fatal(1);
  end

  initial begin
    @(posedge clk); #1;
    step();                       // rst held: reset values checked, model reset
    rst = 1'b0;
    step();

    // 1: all requesters continuously valid, sel = i*10
    for (int i = 0; i < N; i++) set_req(i, 1'b1, SW'(i*10), 1'(i));
    repeat (9) step();
    drain();

    // 2: single requester 2 at the top address
    set_req(2, 1'b1, 10'h3FF, 1'b1);
    step();
    req_valid = '0;
    repeat (3) step();
    drain();

    // 3: scan 5..8 while all requesters wait; a second scan_start mid-scan is ignored
    for (int i = 0; i < N; i++) set_req(i, 1'b1, SW'(100 + i), 1'b1);
    pulse_scan(10'd5, 10'd8);
    step();
    scan_start = 1'b1; scan_lo = 10'd200; scan_hi = 10'd300;
    step();
    scan_start = 1'b0;
    repeat (6) step();
    drain();

    // 4: wrapping scan 0x3FE..0x001
    pulse_scan(10'h3FE, 10'h001);
    repeat (6) step();
    drain();

    // lo == hi: one address
    pulse_scan(10'd77, 10'd77);
    repeat (3) step();
    drain();

    // 5: reset in the second cycle of a scan
    pulse_scan(10'd0, 10'd20);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    repeat (4) step();
    drain();

    // 6: burst then silence, dmx_sel must hold
    set_req(1, 1'b1, 10'h155, 1'b1);
    set_req(3, 1'b1, 10'h2AA, 1'b0);
    repeat (3) step();
    req_valid = '0;
    repeat (5) step();
    drain();

    // random traffic with occasional short scans
    for (int c = 0; c < 300; c++) begin
      for (int i = 0; i < N; i++)
        set_req(i, 1'($urandom_range(0, 1)), SW'($urandom), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 19) == 0) begin
        scan_start = 1'b1;
        scan_lo = SW'($urandom);
        scan_hi = scan_lo + SW'($urandom_range(0, 5));
      end else begin
        scan_start = 1'b0;
      end
      step();
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
